// File: rtl/ctu_clsp_cmpgen.sv
// ctu_clsp_cmpgen: CMP-domain source for the CTU clock/reset distribution.
// Drives start-clock, global reset, debug-init, staggered unit clock enables
// and the JBUS/DRAM sync pulses that the CMP global-interface stage re-times.
// Optional build macro: CTU_CLSP_FAST_SEQ_EN collapses every sequencer
// stagger wait to a single cycle (debug-init length and sync counters unchanged).
module ctu_clsp_cmpgen #(
  parameter int NUM_CKEN = 22,
  parameter int STAGGER  = 4,
  parameter int DBG_LEN  = 16
) (
  input  logic                cmp_gclk,
  input  logic                cmp_rst,
  input  logic                seq_start,
  input  logic                seq_dbginit,
  input  logic [NUM_CKEN-1:0] cken_mask,
  input  logic [4:0]          jbus_ratio,
  input  logic [4:0]          dram_ratio,
  output logic                start_clk_cl,
  output logic                cmp_grst_cl_l,
  output logic                cmp_dbginit_cl_l,
  output logic [NUM_CKEN-1:0] cken_cl,
  output logic                ctu_jbus_tx_sync_cl,
  output logic                ctu_jbus_rx_sync_cl,
  output logic                ctu_dram_tx_sync_cl,
  output logic                ctu_dram_rx_sync_cl,
  output logic                seq_busy,
  output logic                seq_done
);

`ifdef CTU_CLSP_FAST_SEQ_EN
  localparam int STG_CYC = 1;
`else
  localparam int STG_CYC = (STAGGER < 1) ? 1 : STAGGER;
`endif
  localparam int DBG_CYC = (DBG_LEN < 1) ? 1 : DBG_LEN;
  localparam int STEP_MAX = (STG_CYC > DBG_CYC) ? STG_CYC : DBG_CYC;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam int IDX_W    = (NUM_CKEN > 1) ? $clog2(NUM_CKEN) : 1;

  localparam logic [STEP_W-1:0] STG_LAST = STEP_W'(STG_CYC - 1);
  localparam logic [STEP_W-1:0] DBG_LAST = STEP_W'(DBG_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CKEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STCLK,
    S_CKEN,
    S_SYNCW,
    S_GRST,
    S_RUN,
    S_DBG
  } state_e;

  // Ratio counter: position within the period and the period latched at wrap.
  typedef struct packed {
    logic [4:0] cnt;
    logic [4:0] r;
  } sync_t;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                start_clk_q, start_clk_d;
  logic                grst_l_q, grst_l_d;
  logic                dbginit_l_q, dbginit_l_d;
  logic [NUM_CKEN-1:0] cken_q, cken_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  sync_t               jbus_q, jbus_d;
  sync_t               dram_q, dram_d;
  logic                jbus_tx_q, jbus_tx_d, jbus_rx_q, jbus_rx_d;
  logic                dram_tx_q, dram_tx_d, dram_rx_q, dram_rx_d;

  // Counter held at 0 until the clock starts; otherwise 0..R-1, with R
  // re-latched (and clamped to 2 minimum) only at the wrap to 0.
  function automatic sync_t sync_next(input logic run, input sync_t cur,
                                      input logic [4:0] ratio);
    sync_t      nxt;
    logic [4:0] r_eff;
    r_eff = (ratio < 5'd2) ? 5'd2 : ratio;
    nxt   = cur;
    if (!run || (cur.cnt == cur.r - 5'd1)) begin
      nxt.cnt = '0;
      nxt.r   = r_eff;
    end else begin
      nxt.cnt = cur.cnt + 5'd1;
    end
    return nxt;
  endfunction

  // Sequencer next-state and next-output logic.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    step_d      = step_q;
    idx_d       = idx_q;
    start_clk_d = start_clk_q;
    grst_l_d    = grst_l_q;
    dbginit_l_d = dbginit_l_q;
    cken_d      = cken_q;

    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          state_d     = S_STCLK;
          start_clk_d = 1'b1;
          step_d      = '0;
        end
      end

      // Leaving STCLK already writes unit 0 so the walk starts right away.
      S_STCLK: begin
        if (step_q == STG_LAST) begin
          step_d    = '0;
          cken_d[0] = cken_mask[0];
          if (NUM_CKEN == 1) begin
            state_d = S_SYNCW;
          end else begin
            state_d = S_CKEN;
            idx_d   = IDX_W'(1);
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      S_CKEN: begin
        if (step_q == STG_LAST) begin
          step_d         = '0;
          cken_d[idx_q]  = cken_mask[idx_q];
          if (idx_q == IDX_LAST) begin
            state_d = S_SYNCW;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      // Release reset only when both slow domains are at a period boundary.
      S_SYNCW: begin
        if ((jbus_q.cnt == 5'd0) && (dram_q.cnt == 5'd0)) begin
          state_d     = S_GRST;
          grst_l_d    = 1'b1;
          dbginit_l_d = 1'b1;
          step_d      = '0;
        end
      end

      S_GRST: begin
        if (step_q == STG_LAST) begin
          state_d = S_RUN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      // Warm reset outranks a debug-init request arriving in the same cycle.
      S_RUN: begin
        cken_d = cken_mask;
        if (seq_start) begin
          state_d     = S_CKEN;
          grst_l_d    = 1'b0;
          dbginit_l_d = 1'b0;
          cken_d      = '0;
          idx_d       = '0;
          step_d      = '0;
        end else if (seq_dbginit) begin
          state_d     = S_DBG;
          dbginit_l_d = 1'b0;
          step_d      = '0;
        end
      end

      S_DBG: begin
        if (step_q == DBG_LAST) begin
          state_d     = S_RUN;
          dbginit_l_d = 1'b1;
          step_d      = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = state_d inside {S_STCLK, S_CKEN, S_SYNCW, S_GRST, S_DBG};
    done_d = (state_q == S_GRST) && (state_d == S_RUN);
  end

  // Sync counters and their registered rx/tx pulses.
  always_comb begin
    jbus_d    = sync_next(start_clk_q, jbus_q, jbus_ratio);
    dram_d    = sync_next(start_clk_q, dram_q, dram_ratio);
    jbus_rx_d = start_clk_d && (jbus_d.cnt == 5'd0);
    jbus_tx_d = start_clk_d && (jbus_d.cnt == jbus_d.r - 5'd1);
    dram_rx_d = start_clk_d && (dram_d.cnt == 5'd0);
    dram_tx_d = start_clk_d && (dram_d.cnt == dram_d.r - 5'd1);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge cmp_gclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (cmp_rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      idx_q       <= '0;
      start_clk_q <= 1'b0;
      grst_l_q    <= 1'b0;
      dbginit_l_q <= 1'b0;
      cken_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      jbus_q      <= '0;
      dram_q      <= '0;
      jbus_tx_q   <= 1'b0;
      jbus_rx_q   <= 1'b0;
      dram_tx_q   <= 1'b0;
      dram_rx_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      start_clk_q <= start_clk_d;
      grst_l_q    <= grst_l_d;
      dbginit_l_q <= dbginit_l_d;
      cken_q      <= cken_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      jbus_q      <= jbus_d;
      dram_q      <= dram_d;
      jbus_tx_q   <= jbus_tx_d;
      jbus_rx_q   <= jbus_rx_d;
      dram_tx_q   <= dram_tx_d;
      dram_rx_q   <= dram_rx_d;
    end
  end

  assign start_clk_cl        = start_clk_q;
  assign cmp_grst_cl_l       = grst_l_q;
  assign cmp_dbginit_cl_l    = dbginit_l_q;
  assign cken_cl             = cken_q;
  assign ctu_jbus_tx_sync_cl = jbus_tx_q;
  assign ctu_jbus_rx_sync_cl = jbus_rx_q;
  assign ctu_dram_tx_sync_cl = dram_tx_q;
  assign ctu_dram_rx_sync_cl = dram_rx_q;
  assign seq_busy            = busy_q;
  assign seq_done            = done_q;

endmodule

// File: tb/tb_ctu_clsp_cmpgen.sv
// tb_ctu_clsp_cmpgen: directed self-checking bench for ctu_clsp_cmpgen
// (default parameters; CTU_CLSP_FAST_SEQ_EN selects the fast-sequence test).
module tb_ctu_clsp_cmpgen;
  localparam int N = 22;

  logic         cmp_gclk = 1'b0;
  logic         cmp_rst;
  logic         seq_start;
  logic         seq_dbginit;
  logic [N-1:0] cken_mask;
  logic [4:0]   jbus_ratio;
  logic [4:0]   dram_ratio;
  logic         start_clk_cl;
  logic         cmp_grst_cl_l;
  logic         cmp_dbginit_cl_l;
  logic [N-1:0] cken_cl;
  logic         ctu_jbus_tx_sync_cl;
  logic         ctu_jbus_rx_sync_cl;
  logic         ctu_dram_tx_sync_cl;
  logic         ctu_dram_rx_sync_cl;
  logic         seq_busy;
  logic         seq_done;

  int checks   = 0;
  int failures = 0;

  ctu_clsp_cmpgen dut (
    .cmp_gclk            (cmp_gclk),
    .cmp_rst             (cmp_rst),
    .seq_start           (seq_start),
    .seq_dbginit         (seq_dbginit),
    .cken_mask           (cken_mask),
    .jbus_ratio          (jbus_ratio),
    .dram_ratio          (dram_ratio),
    .start_clk_cl        (start_clk_cl),
    .cmp_grst_cl_l       (cmp_grst_cl_l),
    .cmp_dbginit_cl_l    (cmp_dbginit_cl_l),
    .cken_cl             (cken_cl),
    .ctu_jbus_tx_sync_cl (ctu_jbus_tx_sync_cl),
    .ctu_jbus_rx_sync_cl (ctu_jbus_rx_sync_cl),
    .ctu_dram_tx_sync_cl (ctu_dram_tx_sync_cl),
    .ctu_dram_rx_sync_cl (ctu_dram_rx_sync_cl),
    .seq_busy            (seq_busy),
    .seq_done            (seq_done)
  );

  always #5 cmp_gclk = ~cmp_gclk;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge cmp_gclk);
    #1;
  endtask

  // Mask with the lowest n bits set.
  function automatic logic [N-1:0] low_bits(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Flags packed as {start, grst_l, dbginit_l, busy, done, jrx, jtx, drx, dtx}.
  function automatic logic [8:0] flags();
    return {start_clk_cl, cmp_grst_cl_l, cmp_dbginit_cl_l, seq_busy, seq_done,
            ctu_jbus_rx_sync_cl, ctu_jbus_tx_sync_cl,
            ctu_dram_rx_sync_cl, ctu_dram_tx_sync_cl};
  endfunction

  task automatic test_reset();
    cmp_rst     = 1'b1;
    seq_start   = 1'b0;
    seq_dbginit = 1'b0;
    cken_mask   = '1;
    jbus_ratio  = 5'd4;
    dram_ratio  = 5'd6;
    tick();
    tick();
    checks++;
    if (flags() !== 9'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", flags(), 9'b0);
    end
    checks++;
    if (cken_cl !== '0) begin
      failures++;
      $display("FAIL reset_cken got=%h exp=%h", cken_cl, {N{1'b0}});
    end
    cmp_rst = 1'b0;
    tick();
    tick();
    checks++;
    if (flags() !== 9'b0) begin
      failures++;
      $display("FAIL idle_hold got=%b exp=%b", flags(), 9'b0);
    end
  endtask

`ifdef CTU_CLSP_FAST_SEQ_EN
  task automatic test_fast_seq();
    int t;
    jbus_ratio = 5'd2;
    dram_ratio = 5'd2;
    cken_mask  = '1;
    seq_start  = 1'b1;
    tick();
    seq_start = 1'b0;
    t = 1;
    while (!seq_done && t < 60) begin
      tick();
      t++;
    end
    checks++;
    if (!seq_done || t > 27) begin
      failures++;
      $display("FAIL fast_seq_done got_cycle=%0d exp_max=27", t);
    end
    checks++;
    if (cken_cl !== '1) begin
      failures++;
      $display("FAIL fast_seq_cken got=%h exp=%h", cken_cl, {N{1'b1}});
    end
  endtask
`else
  // Full power-up: seq_start sampled, then cycle-by-cycle expectations.
  task automatic test_power_up();
    logic [8:0]   ef;
    logic [N-1:0] ec;
    int           n;
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    for (int t = 1; t <= 104; t++) begin
      n  = (t < 5) ? 0 : (((t - 5) / 4 + 1 > N) ? N : (t - 5) / 4 + 1);
      ec = low_bits(n);
      ef = {1'b1, (t >= 98), (t >= 98), (t <= 101), (t == 102),
            ((t - 1) % 4 == 0), ((t - 1) % 4 == 3),
            ((t - 1) % 6 == 0), ((t - 1) % 6 == 5)};
      checks++;
      if (flags() !== ef) begin
        failures++;
        $display("FAIL powerup_flags t=%0d got=%b exp=%b", t, flags(), ef);
      end
      checks++;
      if (cken_cl !== ec) begin
        failures++;
        $display("FAIL powerup_cken t=%0d got=%h exp=%h", t, cken_cl, ec);
      end
      tick();
    end
  endtask

  // jbus ratio 4 -> 7 mid-period -> 1 (clamped to 2).
  task automatic test_sync_ratio();
    logic [1:0] exp_rt;
    int k;
    k = 0;
    while (!ctu_jbus_rx_sync_cl && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (!ctu_jbus_rx_sync_cl) begin
      failures++;
      $display("FAIL ratio_align got=%b exp=%b", ctu_jbus_rx_sync_cl, 1'b1);
      return;
    end
    for (int s = 1; s <= 22; s++) begin
      tick();
      if (s == 1)  jbus_ratio = 5'd7;
      if (s == 12) jbus_ratio = 5'd1;
      exp_rt = {(s == 4 || s == 11 || s == 18 || s == 20 || s == 22),
                (s == 3 || s == 10 || s == 17 || s == 19 || s == 21)};
      checks++;
      if ({ctu_jbus_rx_sync_cl, ctu_jbus_tx_sync_cl} !== exp_rt) begin
        failures++;
        $display("FAIL ratio_rxtx s=%0d got=%b exp=%b", s,
                 {ctu_jbus_rx_sync_cl, ctu_jbus_tx_sync_cl}, exp_rt);
      end
    end
    jbus_ratio = 5'd4;
  endtask

  task automatic test_dbginit();
    logic [4:0] ef;
    seq_dbginit = 1'b1;
    tick();
    seq_dbginit = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      ef = {1'b1, 1'b1, (t >= 17), (t <= 16), 1'b0};
      checks++;
      if (flags() >> 4 !== 9'(ef)) begin
        failures++;
        $display("FAIL dbginit_flags t=%0d got=%b exp=%b", t, flags() >> 4, ef);
      end
      checks++;
      if (cken_cl !== '1) begin
        failures++;
        $display("FAIL dbginit_cken t=%0d got=%h exp=%h", t, cken_cl, {N{1'b1}});
      end
      tick();
    end
  endtask

  // Simultaneous start+dbginit takes warm reset; cmp_rst mid-walk goes idle.
  task automatic test_warm_reset();
    logic [N-1:0] ec;
    logic [4:0]   ef;
    int           n;
    seq_start   = 1'b1;
    seq_dbginit = 1'b1;
    tick();
    seq_start   = 1'b0;
    seq_dbginit = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      n  = (t < 5) ? 0 : (t - 5) / 4 + 1;
      ec = low_bits(n);
      ef = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (flags() >> 4 !== 9'(ef)) begin
        failures++;
        $display("FAIL warm_flags t=%0d got=%b exp=%b", t, flags() >> 4, ef);
      end
      checks++;
      if (cken_cl !== ec) begin
        failures++;
        $display("FAIL warm_cken t=%0d got=%h exp=%h", t, cken_cl, ec);
      end
      if (t < 12) tick();
    end
    cmp_rst = 1'b1;
    tick();
    cmp_rst = 1'b0;
    checks++;
    if (flags() !== 9'b0 || cken_cl !== '0) begin
      failures++;
      $display("FAIL midwalk_rst got=%b/%h exp=%b/%h", flags(), cken_cl, 9'b0, {N{1'b0}});
    end
    seq_dbginit = 1'b1;
    tick();
    seq_dbginit = 1'b0;
    tick();
    tick();
    checks++;
    if (flags() !== 9'b0 || cken_cl !== '0) begin
      failures++;
      $display("FAIL idle_ignore got=%b/%h exp=%b/%h", flags(), cken_cl, 9'b0, {N{1'b0}});
    end
  endtask

  task automatic test_mask_run();
    int k;
    cken_mask = 22'h3FFF00;
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    k = 0;
    while (!seq_done && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (!seq_done) begin
      failures++;
      $display("FAIL mask_done got=%b exp=%b", seq_done, 1'b1);
    end
    checks++;
    if (cken_cl !== 22'h3FFF00) begin
      failures++;
      $display("FAIL mask_walk got=%h exp=%h", cken_cl, 22'h3FFF00);
    end
    cken_mask = 22'h1FFF00;
    checks++;
    if (cken_cl !== 22'h3FFF00) begin
      failures++;
      $display("FAIL mask_latency got=%h exp=%h", cken_cl, 22'h3FFF00);
    end
    tick();
    checks++;
    if (cken_cl !== 22'h1FFF00) begin
      failures++;
      $display("FAIL mask_follow got=%h exp=%h", cken_cl, 22'h1FFF00);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CTU_CLSP_FAST_SEQ_EN
    test_fast_seq();
`else
    test_power_up();
    test_sync_ratio();
    test_dbginit();
    test_warm_reset();
    test_mask_run();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
